// File: rtl/seven_seg_scanner.sv
// Purpose: time-multiplexed N-digit seven-segment driver with shadow register, blanking, LZ suppression, DP.
// Latency: every output is registered from the current scan state and shadow, so the delay is one cycle.
// Backpressure: none; the scan free-runs and a load is a single-edge capture that never stalls.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  // Shadow copies of the display inputs
  logic [4*NUM_DIGITS-1:0] digits_s_q, digits_s_d;
  logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
  logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
  // Registered outputs
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    frame_tick_q, frame_tick_d;

  // Helpers
  logic [NUM_DIGITS-1:0]   lz_from;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    in_guard;
  logic                    dark;

  // Active-low GFEDCBA pattern for one hex nibble.
  function automatic logic [6:0] hex_to_segs(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter and digit index; frame_tick fires on the wrap back to digit 0.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Shadow capture on load; values are held otherwise.
  always_comb begin
    digits_s_d = load ? digits     : digits_s_q;
    blank_s_d  = load ? blank_mask : blank_s_q;
    dp_s_d     = load ? dp_mask    : dp_s_q;
  end

  // lz_from[k] is set when nibbles k..N-1 of the shadow are all zero.
  always_comb begin
    zero_above = 1'b1;
    lz_from    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (digits_s_q[4*k +: 4] == 4'h0);
      lz_from[k] = zero_above;
    end
  end

  // Next output values: guard band dark, else drive the current digit (DP ignores blanking/LZ).
  always_comb begin
    cur_nib  = digits_s_q[{idx_q, 2'b00} +: 4];
    in_guard = (cnt_q < GUARD_LIM);
    dark     = blank_s_q[idx_q] | (lz_en & (idx_q != '0) & lz_from[idx_q]);
    anode_d  = '1;
    segs_d   = 7'h7F;
    dp_d     = 1'b1;
    if (!in_guard) begin
      anode_d[idx_q] = 1'b0;
      dp_d           = ~dp_s_q[idx_q];
      if (!dark) begin
        segs_d = hex_to_segs(cur_nib);
      end
    end
  end

  // State and output registers; reset blanks the display and restarts the scan at digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      digits_s_q   <= '0;
      blank_s_q    <= '0;
      dp_s_q       <= '0;
      anode_q      <= '1;
      segs_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      digits_s_q   <= digits_s_d;
      blank_s_q    <= blank_s_d;
      dp_s_q       <= dp_s_d;
      anode_q      <= anode_d;
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign segs       = segs_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Purpose: scoreboard bench for seven_seg_scanner with 4 digits, 4-cycle slots, 1-cycle guard.
// Latency: expectations are queued per output cycle; the monitor pops one entry per falling edge while enabled.
// Backpressure: not applicable; the display scan free-runs.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segs;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .blank_mask(blank_mask),
    .dp_mask   (dp_mask),
    .lz_en     (lz_en),
    .load      (load),
    .anode     (anode),
    .segs      (segs),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       ft;
    int         tag;
    int         pos;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   push_pos = 0;

  // Decode table written out by hand (active-low GFEDCBA).
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic cmp(input string name, input exp_t e);
    checks++;
    if (anode !== e.an || segs !== e.sg || dp !== e.dp || frame_tick !== e.ft) begin
      errors++;
      $display("FAIL %s: got anode=%b segs=%h dp=%b ft=%b, want anode=%b segs=%h dp=%b ft=%b",
               name, anode, segs, dp, frame_tick, e.an, e.sg, e.dp, e.ft);
    end
  endtask

  task automatic cmp_reset(input string name);
    exp_t e;
    e = '{an: 4'hF, sg: 7'h7F, dp: 1'b1, ft: 1'b0, tag: 0, pos: 0};
    cmp(name, e);
  endtask

  // Monitor: every falling edge while enabled, pop the next expected output and compare.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output anode=%b segs=%h with no expectation queued, want a queued entry",
                 anode, segs);
      end else begin
        mon_e = sb_q.pop_front();
        cmp($sformatf("t%0d_p%0d", mon_e.tag, mon_e.pos), mon_e);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [3:0] an, input logic [6:0] sg, input logic d,
                            input logic ft, input int tag);
    exp_t e;
    e = '{an: an, sg: sg, dp: d, ft: ft, tag: tag, pos: push_pos};
    push_pos++;
    sb_q.push_back(e);
  endtask

  // One slot: a guard cycle, then three lit cycles; the last cycle of digit 3 carries frame_tick.
  task automatic push_slot(input int k, input logic [6:0] sa, input logic [6:0] sb,
                           input logic [6:0] sc, input logic d, input int tag);
    logic [3:0] a;
    a    = 4'hF;
    a[k] = 1'b0;
    push_entry(4'hF, 7'h7F, 1'b1, 1'b0, tag);
    push_entry(a, sa, d, 1'b0, tag);
    push_entry(a, sb, d, 1'b0, tag);
    push_entry(a, sc, d, (k == 3), tag);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpm, input int tag);
    logic [6:0] sv [4];
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    push_pos = 0;
    for (int k = 0; k < 4; k++) push_slot(k, sv[k], sv[k], sv[k], ~dpm[k], tag);
  endtask

  task automatic end_window(input int tag);
    mon_en = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover_t%0d: got %0d unconsumed entries, want 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_frame(input int tag);
    mon_en = 1'b1;
    repeat (16) tick();
    end_window(tag);
  endtask

  task automatic wait_frame(input int tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_sync_t%0d: got no frame_tick within 40 cycles, want one pulse", tag);
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dpm);
    digits     = d;
    blank_mask = b;
    dp_mask    = dpm;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time 200000, want finish");
    $fatal(1);
  end

  initial begin
    // 1: reset values, including between clock edges
    #1 reset = 1'b1;
    #1 cmp_reset("t1_async");
    push_pos = 0;
    for (int i = 0; i < 3; i++) push_entry(4'hF, 7'h7F, 1'b1, 1'b0, 1);
    mon_en = 1'b1;
    repeat (3) tick();
    end_window(1);
    reset = 1'b0;

    // 2: 1234 over two consecutive frames
    load_word(16'h1234, 4'h0, 4'h0);
    wait_frame(2);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'h0, 2);
    run_frame(2);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'h0, 2);
    run_frame(2);

    // 3: full decode table on digit 0
    for (int v = 0; v < 16; v++) begin
      load_word({12'h000, 4'(v)}, 4'h0, 4'h0);
      wait_frame(300 + v);
      push_frame(dec_tab[v], 7'h40, 7'h40, 7'h40, 4'h0, 300 + v);
      run_frame(300 + v);
    end

    // 4: leading-zero suppression, blanking, decimal point
    lz_en = 1'b1;
    load_word(16'h0070, 4'h0, 4'h0);
    wait_frame(41);
    push_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 4'h0, 41);
    run_frame(41);
    load_word(16'h0000, 4'h0, 4'b0100);
    wait_frame(42);
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0100, 42);
    run_frame(42);
    load_word(16'h0507, 4'h0, 4'h0);
    wait_frame(43);
    push_frame(7'h78, 7'h40, 7'h12, 7'h7F, 4'h0, 43);
    run_frame(43);
    lz_en = 1'b0;
    load_word(16'h1234, 4'b0010, 4'h0);
    wait_frame(44);
    push_frame(7'h19, 7'h7F, 7'h24, 7'h79, 4'h0, 44);
    run_frame(44);

    // 5: load pulse in the middle of digit 1's slot
    load_word(16'h1234, 4'h0, 4'h0);
    wait_frame(51);
    push_pos = 0;
    push_slot(0, 7'h19, 7'h19, 7'h19, 1'b1, 51);
    push_slot(1, 7'h30, 7'h46, 7'h46, 1'b1, 51);
    push_slot(2, 7'h03, 7'h03, 7'h03, 1'b1, 51);
    push_slot(3, 7'h08, 7'h08, 7'h08, 1'b1, 51);
    mon_en = 1'b1;
    repeat (5) tick();
    digits = 16'hABCD;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    repeat (10) tick();
    end_window(51);
    // inputs change without load: display must keep ABCD
    digits     = 16'hFFFF;
    blank_mask = 4'hF;
    dp_mask    = 4'hF;
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'h0, 52);
    run_frame(52);

    // 6: reset at idx=2, cnt=2, then restart from digit 0 with a cleared shadow
    repeat (10) tick();
    reset = 1'b1;
    #1 cmp_reset("t6_async");
    repeat (2) tick();
    cmp_reset("t6_held");
    reset = 1'b0;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0, 6);
    run_frame(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
